// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with wrap-bit pointers (all DEPTH entries usable),
// fill level, programmable almost-full/almost-empty, sticky error flags and flush.
module sync_fifo_ctl #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 256,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       w_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       r_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0] AF_T = 32'(AFULL_THRESH);
  localparam logic [31:0] AE_T = 32'(AEMPTY_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     w_ptr, r_ptr;
  logic              rd, wr;

  // Status decodes from registered pointers only; no input reaches an output combinationally.
  assign empty        = (w_ptr == r_ptr);
  assign full         = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign level        = w_ptr - r_ptr;
  // Compare at 32 bits so a threshold above DEPTH simply never matches.
  assign almost_full  = (32'(level) >= AF_T);
  assign almost_empty = (32'(level) <= AE_T);

  // A read at full frees a slot, so a paired write is taken in the same cycle.
  assign rd = r_en & ~empty;
  assign wr = w_en & (~full | rd);

  // Pointer and sticky error-flag update; flush overrides any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr) w_ptr <= w_ptr + 1'b1;
      if (rd) r_ptr <= r_ptr + 1'b1;
      if (w_en & ~wr) overflow  <= 1'b1;
      if (r_en & empty) underflow <= 1'b1;
    end
  end

  // Storage write port; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr && !clr) mem[w_ptr[AW-1:0]] <= data_in;
  end

  // Synchronous read port; holds its value until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_out <= '0;
    else if (clr)  data_out <= '0;
    else if (rd)   data_out <= mem[r_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed plus randomized stimulus against a queue-based reference model.
module tb_sync_fifo_ctl;
  localparam int DW = 9, DEPTH = 16, AF = 12, AE = 2, LW = 5;

  logic clk = 1'b0;
  logic rst, clr, w_en, r_en;
  logic [DW-1:0] data_in, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [LW-1:0] level;

  sync_fifo_ctl #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, checks = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic m_of, m_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level", 32'(level), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_of));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  // Reference behaviour: a read needs data; a write needs room or a paired read.
  task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    bit do_rd, do_wr;
    if (c) begin
      model_reset();
      return;
    end
    do_rd = r && (q.size() > 0);
    do_wr = w && ((q.size() < DEPTH) || do_rd);
    if (r && q.size() == 0) m_uf = 1'b1;
    if (w && !do_wr) m_of = 1'b1;
    if (do_rd) m_dout = q.pop_front();
    if (do_wr) q.push_back(d);
  endtask

  task automatic cycle(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    check_all();
    clr = c; w_en = w; r_en = r; data_in = d;
    model_step(c, w, r, d);
    vectors++;
  endtask

  initial begin
    int wp, rp;
    rst = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // Fill past full: last write is rejected and sets overflow.
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i + 1));
    // Paired write/read at full: both accepted, level unchanged.
    cycle(1'b0, 1'b1, 1'b1, 9'h0AA);
    // Drain past empty: last read rejected and sets underflow.
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    // Paired write/read at empty: write only, no fall-through.
    cycle(1'b0, 1'b1, 1'b1, 9'h055);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, DW'(9'h100 + i));
    // Flush with a concurrent write: flush wins.
    cycle(1'b1, 1'b1, 1'b0, 9'h077);
    cycle(1'b0, 1'b0, 1'b1, '0);

    // Randomized phases biased toward filling, draining, and balanced traffic.
    for (int p = 0; p < 9; p++) begin
      wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int k = 0; k < 150; k++)
        cycle($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < wp,
              $urandom_range(0, 99) < rp,
              DW'($urandom));
    end

    // Asynchronous reset between edges, mid-burst.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(9'h1F0 + i));
    cycle(1'b0, 1'b1, 1'b1, 9'h0C3);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DW'(9'h0E0 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
